// File: rtl/mem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_pkg : shared types for the data-memory access stage          |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
package mem_pkg;

    typedef logic        u1;
    typedef logic [3:0]  u4;
    typedef logic [31:0] u32;

    typedef enum logic [1:0] {
        MS_BYTE = 2'd0,
        MS_HALF = 2'd1,
        MS_WORD = 2'd2
    } memsize_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_load_fmt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_load_fmt : lane select and sign/zero extension of load data |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module dmem_load_fmt
    import mem_pkg::*;
(
    input  u32         rdata,
    input  logic [1:0] offset,
    input  logic [1:0] size,
    input  u1          is_unsigned,
    output u32         fmt_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (offset)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = offset[1] ? rdata[31:16] : rdata[15:0];

        if (size == MS_BYTE)
            fmt_data = {{24{~is_unsigned & w_byte[7]}}, w_byte};
        else if (size == MS_HALF)
            fmt_data = {{16{~is_unsigned & w_half[15]}}, w_half};
        else
            fmt_data = rdata;
    end

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_ctrl : load/store bus master with stall, misalign, timeout  |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module dmem_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [1:0]  memsize,
    input  logic        memunsigned,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        misalign,
    output logic        buserr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam int              c_cnt_w    = cnt_width(TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    dmem_state_t         r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    u32                  r_addr;
    u32                  r_wdata;
    u32                  r_rdata;
    logic [1:0]          r_size;
    u1                   r_uns;
    u1                   r_we;
    u1                   r_err;
    u4                   r_be;

    u1                   w_access;
    u1                   w_misalign;
    u1                   w_start;
    u4                   w_be;
    u32                  w_wdata;
    u32                  w_fmt;

    assign w_access   = memread | memwrite;
    assign w_misalign = w_access & (((memsize == MS_HALF) & addr[0]) |
                                    (memsize[1] & (addr[1:0] != 2'b00)));
    assign w_start    = w_access & ~w_misalign;

    // Loads always fetch the whole word; lanes are picked on the way back.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = writedata;
        if (memwrite) begin
            if (memsize == MS_BYTE) begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{writedata[7:0]}};
            end else if (memsize == MS_HALF) begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{writedata[15:0]}};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_size  <= '0;
            r_uns   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_be    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_addr  <= addr;
                        r_size  <= memsize;
                        r_uns   <= memunsigned;
                        r_we    <= memwrite;
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus_ready) begin
                        r_rdata <= bus_rdata;
                        r_state <= DONE;
                    end else if (r_cnt == c_cnt_last) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    dmem_load_fmt u_load_fmt (
        .rdata       (r_rdata),
        .offset      (r_addr[1:0]),
        .size        (r_size),
        .is_unsigned (r_uns),
        .fmt_data    (w_fmt)
    );

    assign misalign  = w_misalign;
    assign stall     = (r_state == WAIT) | ((r_state == IDLE) & w_start);
    assign bus_req   = (r_state == WAIT);
    assign bus_we    = (r_state == WAIT) & r_we;
    assign bus_addr  = {r_addr[31:2], 2'b00};
    assign bus_be    = r_be;
    assign bus_wdata = r_wdata;
    assign buserr    = (r_state == DONE) & r_err;
    assign readdata  = ((r_state == DONE) && !r_err) ? w_fmt : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dmem_ctrl : randomized bench with a byte-level memory model   |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module tb_dmem_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread, memwrite, memunsigned, bus_ready;
    logic [1:0]  memsize;
    logic [31:0] addr, writedata, readdata, bus_addr, bus_wdata, bus_rdata;
    logic        stall, misalign, buserr, bus_req, bus_we;
    logic [3:0]  bus_be;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mem [16];

    always #5 clk = ~clk;

    dmem_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .memread     (memread),
        .memwrite    (memwrite),
        .memsize     (memsize),
        .memunsigned (memunsigned),
        .addr        (addr),
        .writedata   (writedata),
        .readdata    (readdata),
        .stall       (stall),
        .misalign    (misalign),
        .buserr      (buserr),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_ready   (bus_ready),
        .bus_rdata   (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] word, input logic [31:0] a,
                                             input logic [1:0] sz, input bit uns);
        int          n  = nbytes(sz);
        int          sh = 8 * int'(a % 4);
        logic [31:0] v;
        if (n == 4) return word;
        v = (word >> sh) & ((n == 1) ? 32'hFF : 32'hFFFF);
        if (!uns && v >= (32'd1 << (8 * n - 1)))
            v = v | ((n == 1) ? 32'hFFFF_FF00 : 32'hFFFF_0000);
        return v;
    endfunction

    // One access from IDLE through DONE; the bus answers after dly wait cycles.
    task automatic do_access(input bit wr, input logic [1:0] sz, input bit uns,
                             input logic [31:0] a, input logic [31:0] wd, input int dly);
        int          n;
        int          idx;
        bit          mis;
        bit          tmo;
        logic [31:0] word;
        logic [3:0]  ebe;
        logic [31:0] ew;
        n    = nbytes(sz);
        mis  = (a % n) != 0;
        idx  = int'(a[5:2]);
        word = mem[idx];
        ebe  = wr ? 4'(((1 << n) - 1) << (a % 4)) : 4'hF;
        ew   = (n == 1) ? wd[7:0] * 32'h0101_0101 :
               (n == 2) ? wd[15:0] * 32'h0001_0001 : wd;
        tmo  = dly >= TMO;

        memwrite    = wr;
        memread     = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        memsize     = sz;
        memunsigned = uns;
        addr        = a;
        writedata   = wd;

        @(negedge clk);
        check("misalign", misalign, mis);
        check("readdata_idle", readdata, 0);
        check("buserr_idle", buserr, 0);
        check("bus_req_idle", bus_req, 0);
        if (mis) begin
            check("stall_misalign", stall, 0);
            @(posedge clk); #1;
            memread  = 1'b0;
            memwrite = 1'b0;
            return;
        end
        check("stall_idle", stall, 1);
        @(posedge clk); #1;

        for (int w = 0; w < TMO; w++) begin
            bus_ready = (w == dly);
            bus_rdata = bus_ready ? word : $urandom();
            @(negedge clk);
            check("bus_req_wait", bus_req, 1);
            check("stall_wait", stall, 1);
            check("bus_addr", bus_addr, {a[31:2], 2'b00});
            check("bus_be", bus_be, ebe);
            check("bus_we", bus_we, wr);
            if (wr) check("bus_wdata", bus_wdata, ew);
            @(posedge clk); #1;
            bus_ready = 1'b0;
            bus_rdata = $urandom();
            if (w == dly) break;
        end

        memread  = 1'b0;
        memwrite = 1'b0;
        @(negedge clk);
        check("stall_done", stall, 0);
        check("bus_req_done", bus_req, 0);
        check("buserr_done", buserr, tmo);
        if (!wr || tmo)
            check("readdata_done", readdata, tmo ? 32'h0 : load_val(word, a, sz, uns));
        if (wr && !tmo) begin
            for (int b = 0; b < 4; b++)
                if (ebe[b]) mem[idx][8*b +: 8] = ew[8*b +: 8];
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset       = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memsize     = 2'd0;
        memunsigned = 1'b0;
        addr        = '0;
        writedata   = '0;
        bus_ready   = 1'b0;
        bus_rdata   = '0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom();

        @(negedge clk);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_we", bus_we, 0);
        check("rst_stall", stall, 0);
        check("rst_buserr", buserr, 0);
        check("rst_readdata", readdata, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        mem[0] = 32'h8011_2233;
        do_access(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 0);
        do_access(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 3);
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0, 0);
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0, 10);
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_0024, 32'h0, 0);
        do_access(1'b0, 2'd3, 1'b0, 32'h0000_0028, 32'h0, 1);

        // Reset while the bus is waiting: the request must vanish at once.
        memread = 1'b1; memsize = 2'd2; addr = 32'h0000_0040;
        @(negedge clk);
        check("midrst_stall_idle", stall, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_bus_req_wait", bus_req, 1);
        #1;
        reset   = 1'b0;
        memread = 1'b0;
        #1;
        check("midrst_bus_req", bus_req, 0);
        check("midrst_stall", stall, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        mem[4] = 32'hABCD_1234;
        do_access(1'b0, 2'd1, 1'b1, 32'h0000_0010, 32'h0, 1);
        check("lhu_after_reset_mem", mem[4], 32'hABCD_1234);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            int          dly;
            a = $urandom();
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            dly = ($urandom_range(0, 9) == 0) ? TMO + 1 : int'($urandom_range(0, 3));
            do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), a, $urandom(), dly);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory access stage directly downstream of the single-cycle datapath.
- Consumes aluout (address), writedata and the memory control bits, and runs a valid/ready transaction on a word-wide data bus.
- Returns a formatted readdata to the datapath; handles byte and halfword accesses with byte enables, sign or zero extension and misalignment detection.
- Holds `stall` high while a transaction is outstanding so the PC register and register file do not commit.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT with bus_ready low before the access is aborted with buserr.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- memread  input  1  load request from the controller.
- memwrite  input  1  store request; wins if asserted together with memread.
- memsize  input  2  access size: 0 = byte, 1 = half, 2 = word (3 is treated as word).
- memunsigned  input  1  1 = zero-extend loads, 0 = sign-extend loads.
- addr  input  32  byte address (datapath aluout).
- writedata  input  32  store data (datapath writedata).
- readdata  output  32  formatted load result.
- stall  output  1  core must hold its state this cycle.
- misalign  output  1  misaligned access flag (combinational).
- buserr  output  1  one-cycle timeout pulse.
- bus_req  output  1  bus request valid.
- bus_we  output  1  bus write enable.
- bus_addr  output  32  {addr[31:2],2'b00}.
- bus_be  output  4  byte enables.
- bus_wdata  output  32  lane-replicated store data.
- bus_ready  input  1  bus accepts/completes the transfer this cycle.
- bus_rdata  input  32  read data, valid when bus_ready=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, timeout counter=0, captured data=0.
  - bus_req=0, bus_we=0, stall=0, buserr=0, readdata=0.
  - Reset mid-transaction drops bus_req immediately, with no completion.
- access = memread | memwrite.
- misalign = access & ((half & addr[0]) | (word & addr[1:0]!=0)).
  - A misaligned access starts no transaction.
  - It gives stall=0 and readdata=0, and the FSM stays in IDLE.
- FSM states:
  - IDLE:
    - stall = access & ~misalign.
    - If stall=1: latch addr, size, unsigned flag, we and writedata; go to WAIT.
  - WAIT:
    - bus_req=1, stall=1.
    - bus_addr, bus_we, bus_be and bus_wdata come from the latched values and are stable until bus_ready.
    - On bus_ready=1: capture bus_rdata, go to DONE.
    - When the counter reaches TIMEOUT_CYCLES-1 with bus_ready=0: set the error flag and go to DONE.
    - The counter clears on WAIT entry.
  - DONE:
    - stall=0, bus_req=0; readdata is valid.
    - buserr=1 if the timeout occurred, and readdata is then 0.
    - The core commits on this edge. Next state is IDLE unconditionally.
    - A new access is only recognised in IDLE.
- Latency: a zero-wait access stalls 2 cycles (IDLE, WAIT) and completes in the 3rd cycle. Each wait cycle adds 1.
- Byte lanes are little-endian: byte k occupies bits 8k+7:8k, with k = addr[1:0].
- Stores:
  - byte: be = 1<<k, wdata = {4{wd[7:0]}}.
  - half: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wd[15:0]}}.
  - word: be = 4'b1111.
- Loads:
  - bus_be=4'b1111.
  - The selected byte or half is extracted and extended to 32 bits per memunsigned.
  - Word loads pass through unchanged.
- readdata is 0 outside DONE.
- If memread and memwrite are both asserted, a store is performed.

Decomposition:
- Shared package mem_pkg:
  - memsize_t enum {MS_BYTE=0, MS_HALF=1, MS_WORD=2}.
  - dmem_state_t enum {IDLE, WAIT, DONE}.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
  - Widths use the existing u1/u4/u32 typedefs.
- Natural sub-module: dmem_load_fmt, purely combinational. It takes (rdata, offset, size, unsigned) and produces the 32-bit formatted load value.

Test Plan:
- Load byte, sign-extended: addr=0x1003, memsize=0, memunsigned=0, bus_rdata=0x80112233, ready on first WAIT cycle -> bus_addr=0x1000, be=4'b1111, stall high 2 cycles, readdata=0xFFFFFF80 in DONE.
- Store half: addr=0x2002, writedata=0x0000BEEF, memsize=1, ready after 3 wait cycles -> bus_we=1, be=4'b1100, wdata=0xBEEFBEEF, stall high 5 cycles.
- Misaligned word: memread, addr=0x3001, memsize=2 -> misalign=1, stall=0, bus_req never asserted.
- Timeout: TIMEOUT_CYCLES=4, bus_ready held 0 -> 4 WAIT cycles, then DONE with buserr=1 for one cycle and readdata=0, then IDLE.
- Reset mid-op: assert reset low during WAIT -> bus_req and stall drop in the same cycle. After release, a lhu at 0x10 with rdata=0xABCD1234 returns 0x00001234.
- Back-to-back: two consecutive word loads -> second bus_req asserts exactly one cycle after the first DONE (IDLE in between).
